// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI mode 0 (CPOL=0, CPHA=0) transfer sequencer.
// Produces sclk/cs_n and the single-cycle strobes that steer an external
// transmit PISO (tx_load/tx_shift) and receive SIPO (rx_ena). Holds no data.
// Optional feature: define SPI_BURST_EN to chain frames without releasing
// cs_n when start is high in the final HOLD cycle.
module spi_master_seq #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic cs_n,
  output logic sclk,
  output logic tx_load,
  output logic tx_shift,
  output logic rx_ena
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] bit_cnt;
  logic             phase_end;

  // Every non-idle phase lasts CLK_DIV cycles; this flags its last cycle.
  assign phase_end = (div == DIV_LAST);

  // Sequencer: state, divider, bit counter and all registered outputs.
  // Outputs are assigned together with the state they belong to, so the
  // strobes land in the first cycle of the phase that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div      <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      tx_load  <= 1'b0;
      tx_shift <= 1'b0;
      rx_ena   <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      tx_shift <= 1'b0;
      rx_ena   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          div <= '0;
          if (start) begin
            state   <= SETUP;
            bit_cnt <= '0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            tx_load <= 1'b1;
          end
        end
        // MSB is already on mosi; first rising sclk follows.
        SETUP: begin
          if (phase_end) begin
            div    <= '0;
            state  <= HIGH;
            sclk   <= 1'b1;
            rx_ena <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        HIGH: begin
          if (phase_end) begin
            div  <= '0;
            sclk <= 1'b0;
            if (bit_cnt == CNT_LAST) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              state    <= LOW;
              tx_shift <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        LOW: begin
          if (phase_end) begin
            div    <= '0;
            state  <= HIGH;
            sclk   <= 1'b1;
            rx_ena <= 1'b1;
          end else begin
            div <= div + 1'b1;
          end
        end
        // Trailing half-period keeps cs_n low after the last falling sclk.
        HOLD: begin
          if (phase_end) begin
            div  <= '0;
            done <= 1'b1;
`ifdef SPI_BURST_EN
            if (start) begin
              state   <= SETUP;
              bit_cnt <= '0;
              tx_load <= 1'b1;
            end else begin
              state <= IDLE;
              cs_n  <= 1'b1;
              busy  <= 1'b0;
            end
`else
            state <= IDLE;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
`endif
          end else begin
            div <= div + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          div   <= '0;
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq: two instances (defaults, and
// DATA_W=16/CLK_DIV=1), external PISO/SIPO loopback, transaction model.
module tb_spi_master_seq;
  localparam int W0 = 8;
  localparam int C0 = 4;
  localparam int W1 = 16;
  localparam int C1 = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, busy0, done0, cs_n0, sclk0, tx_load0, tx_shift0, rx_ena0;
  logic start1, busy1, done1, cs_n1, sclk1, tx_load1, tx_shift1, rx_ena1;

  spi_master_seq u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .cs_n(cs_n0), .sclk(sclk0), .tx_load(tx_load0), .tx_shift(tx_shift0),
    .rx_ena(rx_ena0)
  );

  spi_master_seq #(.DATA_W(W1), .CLK_DIV(C1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .cs_n(cs_n1), .sclk(sclk1), .tx_load(tx_load1), .tx_shift(tx_shift1),
    .rx_ena(rx_ena1)
  );

  typedef struct {
    int          len;
    int          n_rx;
    int          n_shift;
    int          n_load;
    int          n_rise;
    int          sclk_hi;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] txq0[$];
  logic [15:0] txq1[$];
  int          gap_q0[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation for one frame.
  function automatic exp_t model(input int w, input int c, input logic [15:0] d);
    exp_t e;
    e.len     = (2 * w + 1) * c;
    e.n_rx    = w;
    e.n_shift = w - 1;
    e.n_load  = 1;
    e.n_rise  = w;
    e.sclk_hi = w * c;
    e.data    = d & 16'((32'h1 << w) - 1);
    return e;
  endfunction

  // External shift registers with mosi looped back to miso.
  logic [15:0] piso[2];
  logic [15:0] sipo[2];
  logic        mosi0, mosi1;
  assign mosi0 = piso[0][W0-1];
  assign mosi1 = piso[1][W1-1];

  always @(posedge clk) begin
    if (tx_load0) begin
      if (txq0.size() > 0) piso[0] <= txq0.pop_front();
      else piso[0] <= '0;
    end else if (tx_shift0) piso[0] <= piso[0] << 1;
    if (rx_ena0) sipo[0] <= {sipo[0][14:0], mosi0};
    if (tx_load1) begin
      if (txq1.size() > 0) piso[1] <= txq1.pop_front();
      else piso[1] <= '0;
    end else if (tx_shift1) piso[1] <= piso[1] << 1;
    if (rx_ena1) sipo[1] <= {sipo[1][14:0], mosi1};
  end

  // Monitor state per instance.
  int open_f[2], len[2], nrx[2], nsh[2], nld[2], nrise[2], nhi[2], ferr[2];
  int prev_sc[2], hi_run[2], last_rx[2], last_sh[2], cyc[2];
  int frames[2], dones[2], strobes[2], rises[2], glob_err[2], gap_run[2];
  int pushes[2];

  task automatic mon(input int id, input int w, input int c, input logic b,
                     input logic d, input logic cs, input logic sc,
                     input logic ld, input logic sh, input logic rx);
    exp_t e;
    cyc[id]++;
    if (rst) begin
      open_f[id] = 0; prev_sc[id] = 0; hi_run[id] = 0;
      return;
    end
    if (ld | sh | rx | d | sc) strobes[id]++;
    if (sc && !prev_sc[id]) rises[id]++;
    if (d) begin
      dones[id]++;
      if (open_f[id] == 0) begin
        chk($sformatf("u%0d_done_outside_frame", id), 1, 0);
      end else if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
        chk($sformatf("u%0d_unexpected_done", id), 1, 0);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("u%0d_busy_len", id), len[id], e.len);
        chk($sformatf("u%0d_rx_ena_cnt", id), nrx[id], e.n_rx);
        chk($sformatf("u%0d_tx_shift_cnt", id), nsh[id], e.n_shift);
        chk($sformatf("u%0d_tx_load_cnt", id), nld[id], e.n_load);
        chk($sformatf("u%0d_sclk_rises", id), nrise[id], e.n_rise);
        chk($sformatf("u%0d_sclk_high_cycles", id), nhi[id], e.sclk_hi);
        chk($sformatf("u%0d_loopback_data", id), sipo[id] & 16'((32'h1 << w) - 1), e.data);
        chk($sformatf("u%0d_frame_timing_errs", id), ferr[id], 0);
        frames[id]++;
      end
      open_f[id] = 0;
    end
    if (ld) begin
      open_f[id] = 1; len[id] = 0; nrx[id] = 0; nsh[id] = 0; nld[id] = 0;
      nrise[id] = 0; nhi[id] = 0; ferr[id] = 0;
      last_rx[id] = -1000; last_sh[id] = -1000;
    end
    if (open_f[id] != 0) begin
      len[id]++;
      if (!b || cs) ferr[id]++;
      if (rx && sh) ferr[id]++;
      if (rx) begin
        nrx[id]++;
        if (cyc[id] - last_sh[id] < c) ferr[id]++;
        last_rx[id] = cyc[id];
      end
      if (sh) begin
        nsh[id]++;
        if (cyc[id] - last_rx[id] < c) ferr[id]++;
        last_sh[id] = cyc[id];
      end
      if (ld) nld[id]++;
      if (sc) nhi[id]++;
      if (sc && !prev_sc[id]) nrise[id]++;
    end else if (b || !cs || sc || sh || rx) begin
      glob_err[id]++;
    end
    if (sc) hi_run[id]++;
    else begin
      if (prev_sc[id] != 0 && hi_run[id] != c) begin
        if (open_f[id] != 0) ferr[id]++; else glob_err[id]++;
      end
      hi_run[id] = 0;
    end
    if (cs) gap_run[id]++;
    else begin
      if (id == 0 && gap_run[0] > 0) gap_q0.push_back(gap_run[0]);
      gap_run[id] = 0;
    end
    prev_sc[id] = sc;
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, W0, C0, busy0, done0, cs_n0, sclk0, tx_load0, tx_shift0, rx_ena0);
    mon(1, W1, C1, busy1, done1, cs_n1, sclk1, tx_load1, tx_shift1, rx_ena1);
  end

  function automatic logic busy_of(input int id);
    return (id == 0) ? busy0 : busy1;
  endfunction

  function automatic logic done_of(input int id);
    return (id == 0) ? done0 : done1;
  endfunction

  task automatic set_start(input int id, input logic v);
    if (id == 0) start0 = v; else start1 = v;
  endtask

  task automatic push_exp(input int id, input logic [15:0] d);
    if (id == 0) begin txq0.push_back(d); q0.push_back(model(W0, C0, d)); end
    else begin txq1.push_back(d); q1.push_back(model(W1, C1, d)); end
    pushes[id]++;
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (!busy_of(id)) return;
    end
    chk($sformatf("u%0d_idle_timeout", id), 1, 0);
  endtask

  task automatic xfer(input int id, input logic [15:0] d);
    wait_idle(id);
    push_exp(id, d);
    set_start(id, 1'b1);
    @(posedge clk); #1;
    set_start(id, 1'b0);
  endtask

  // Issue the next start in the done cycle of the transfer in flight.
  task automatic xfer_on_done(input int id, input logic [15:0] d);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (done_of(id)) begin
        push_exp(id, d);
        set_start(id, 1'b1);
        @(posedge clk); #1;
        set_start(id, 1'b0);
        return;
      end
    end
    chk($sformatf("u%0d_done_timeout", id), 1, 0);
  endtask

  task automatic drain(input int id);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) return;
    end
    chk($sformatf("u%0d_drain_timeout", id), 1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  int base_d, base_r;
  logic [15:0] d;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    piso[0] = '0; piso[1] = '0; sipo[0] = '0; sipo[1] = '0;
    #40 rst = 1'b0;

    // Idle after reset.
    repeat (200) @(posedge clk);
    #1;
    chk("reset_strobes_u0", strobes[0], 0);
    chk("reset_strobes_u1", strobes[1], 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_cs_n", cs_n0, 1);
    chk("reset_sclk", sclk0, 0);
    chk("reset_tx_load", tx_load0, 0);
    chk("reset_tx_shift", tx_shift0, 0);
    chk("reset_rx_ena", rx_ena0, 0);
    chk("reset_cs_n_u1", cs_n1, 1);

    // Single transfer with the loopback pattern.
    xfer(0, 16'h0059);
    drain(0);
    chk("single_done_count", dones[0], 1);

    // Randomised transfers, some started in the done cycle.
    for (int i = 0; i < 8; i++) begin
      xfer(0, 16'($urandom));
      if ($urandom_range(0, 1) == 1) xfer_on_done(0, 16'($urandom));
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    drain(0);

    // Starts while busy are dropped.
    xfer(0, 16'($urandom));
    repeat (10) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1 start0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 start0 = 1'b0;
    drain(0);
    repeat (100) @(posedge clk);

    // Start held across three transfers.
    wait_idle(0);
    for (int i = 0; i < 3; i++) push_exp(0, 16'($urandom));
    start0 = 1'b1;
    for (int i = 0; i < 20 && !busy0; i++) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    gap_q0.delete();
    base_d = dones[0];
    for (int i = 0; i < 400 && dones[0] < base_d + 2; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1 start0 = 1'b0;
    drain(0);
    repeat (5) @(posedge clk);
    chk("held_done_count", dones[0] - base_d, 3);
`ifdef SPI_BURST_EN
    chk("held_cs_gaps", gap_q0.size(), 0);
`else
    chk("held_cs_gaps", gap_q0.size(), 2);
    if (gap_q0.size() == 2) begin
      chk("held_gap0_len", gap_q0[0], 1);
      chk("held_gap1_len", gap_q0[1], 1);
    end
`endif

    // Reset during the fifth sclk high phase.
    wait_idle(0);
    push_exp(0, 16'($urandom));
    base_r = rises[0];
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int i = 0; i < 200 && rises[0] < base_r + 5; i++) begin @(negedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    chk("abort_cs_n", cs_n0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    void'(q0.pop_back());
    pushes[0]--;
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b0;
    base_d = dones[0];
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", dones[0] - base_d, 0);
    chk("abort_stays_idle", busy0, 0);
    xfer(0, 16'h00A5);
    drain(0);

    // Wide/fast instance: randomised, back-to-back, ignored starts.
    xfer(1, 16'($urandom));
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
    end
    drain(1);
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom);
      xfer(1, d);
      if ($urandom_range(0, 1) == 1) xfer_on_done(1, 16'($urandom));
    end
    drain(1);

    repeat (100) @(posedge clk);
    #1;
    chk("u0_frames_total", frames[0], pushes[0]);
    chk("u1_frames_total", frames[1], pushes[1]);
    chk("u0_pending_exp", q0.size(), 0);
    chk("u1_pending_exp", q1.size(), 0);
    chk("u0_idle_activity", glob_err[0], 0);
    chk("u1_idle_activity", glob_err[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
